pkt_src_tx: RTL and testbench

//  Ingress-side packet transmitter for one switch port.
//  - Accepts a descriptor (destination, priority, length, seed).
//  - Emits a framed packet on the wr_sop/wr_eop/wr_vld/wr_data interface that feeds a switch input port.
//  - Throttles on the switch alm_ost_full back-pressure.
//  - Used as the per-port traffic source in external_clk-domain system benches and in BIST mode.

---
 rtl/pkt_src_tx.sv | 169 ++++++++++++++++
 tb/tb_pkt_src_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_src_tx.sv
`default_nettype none
// ============================================================================
// Module      : pkt_src_tx
// Description : Per-port packet transmitter; turns a descriptor into a framed
//               header + payload burst, throttled by switch almost-full.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_src_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int PORT_NUB   = 16,
    parameter int PRIORITY   = 8,
    parameter int LEN_W      = 10,
    parameter int MIN_GAP    = 1
) (
    input  logic                          external_clk,
    input  logic                          rst,
    input  logic                          cmd_vld,
    output logic                          cmd_ready,
    input  logic [$clog2(PORT_NUB)-1:0]   cmd_dst,
    input  logic [$clog2(PRIORITY)-1:0]   cmd_prio,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic [DATA_WIDTH-1:0]         cmd_seed,
    input  logic                          full_in,
    output logic                          wr_sop,
    output logic                          wr_eop,
    output logic                          wr_vld,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          busy,
    output logic [15:0]                   pkt_cnt
);

    localparam int c_port_w = $clog2(PORT_NUB);
    localparam int c_prio_w = $clog2(PRIORITY);
    localparam int c_hdr_w  = c_port_w + c_prio_w + LEN_W;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_head = 2'd1;
    localparam logic [1:0] c_st_body = 2'd2;
    localparam logic [1:0] c_st_gap  = 2'd3;

    localparam logic [3:0] c_gap_last = (MIN_GAP == 0) ? 4'd0 : 4'(MIN_GAP - 1);
    // With no gap configured the packet end lands straight back in IDLE.
    localparam logic [1:0] c_st_after_eop = (MIN_GAP == 0) ? c_st_idle : c_st_gap;
    localparam logic       c_ready_after_eop = (MIN_GAP == 0);

    logic [1:0]            r_state;
    logic                  r_cmd_ready;
    logic [c_port_w-1:0]   r_dst;
    logic [c_prio_w-1:0]   r_prio;
    logic [LEN_W-1:0]      r_len;
    logic [DATA_WIDTH-1:0] r_pay;
    logic [LEN_W-1:0]      r_idx;
    logic [3:0]            r_gap_cnt;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           r_pkt_cnt;
    logic [DATA_WIDTH-1:0] w_header;

    always_comb begin
        w_header                = '0;
        w_header[c_hdr_w-1:0]   = {r_len, r_prio, r_dst};
    end

    always_ff @(posedge external_clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cmd_ready <= 1'b0;
            r_dst       <= '0;
            r_prio      <= '0;
            r_len       <= '0;
            r_pay       <= '0;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_vld       <= 1'b0;
            r_data      <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_vld <= 1'b0;
                    r_sop <= 1'b0;
                    r_eop <= 1'b0;
                    if (r_cmd_ready && cmd_vld) begin
                        r_dst       <= cmd_dst;
                        r_prio      <= cmd_prio;
                        r_len       <= cmd_len;
                        r_pay       <= cmd_seed;
                        r_idx       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= c_st_head;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                c_st_head: begin
                    if (!full_in) begin
                        r_vld  <= 1'b1;
                        r_sop  <= 1'b1;
                        r_data <= w_header;
                        if (r_len == '0) begin
                            r_eop       <= 1'b1;
                            r_pkt_cnt   <= r_pkt_cnt + 16'd1;
                            r_gap_cnt   <= '0;
                            r_cmd_ready <= c_ready_after_eop;
                            r_state     <= c_st_after_eop;
                        end else begin
                            r_eop   <= 1'b0;
                            r_state <= c_st_body;
                        end
                    end else begin
                        r_vld <= 1'b0;
                        r_sop <= 1'b0;
                        r_eop <= 1'b0;
                    end
                end
                c_st_body: begin
                    r_sop <= 1'b0;
                    if (!full_in) begin
                        r_vld  <= 1'b1;
                        r_data <= r_pay;
                        r_pay  <= r_pay + DATA_WIDTH'(1);
                        r_idx  <= r_idx + LEN_W'(1);
                        if (r_idx == r_len - LEN_W'(1)) begin
                            r_eop       <= 1'b1;
                            r_pkt_cnt   <= r_pkt_cnt + 16'd1;
                            r_gap_cnt   <= '0;
                            r_cmd_ready <= c_ready_after_eop;
                            r_state     <= c_st_after_eop;
                        end else begin
                            r_eop <= 1'b0;
                        end
                    end else begin
                        // Back-pressure: bubble inside the packet, word index holds.
                        r_vld <= 1'b0;
                        r_eop <= 1'b0;
                    end
                end
                c_st_gap: begin
                    r_vld <= 1'b0;
                    r_sop <= 1'b0;
                    r_eop <= 1'b0;
                    if (r_gap_cnt == c_gap_last) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= c_st_idle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wr_sop    = r_sop;
    assign wr_eop    = r_eop;
    assign wr_vld    = r_vld;
    assign wr_data   = r_data;
    assign busy      = (r_state != c_st_idle);
    assign pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkt_src_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_src_tx
// Description : Directed self-checking bench for pkt_src_tx (MIN_GAP = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_src_tx;

    localparam int MIN_GAP = 2;

    logic        clk;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_ready;
    logic [3:0]  cmd_dst;
    logic [2:0]  cmd_prio;
    logic [9:0]  cmd_len;
    logic [31:0] cmd_seed;
    logic        full_in;
    logic        wr_sop;
    logic        wr_eop;
    logic        wr_vld;
    logic [31:0] wr_data;
    logic        busy;
    logic [15:0] pkt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Per-packet observations gathered by run_pkt.
    logic [31:0] q_data[$];
    int n_vld, n_sop, n_eop, n_idle, n_span, t_acc, t_sop;

    pkt_src_tx #(
        .DATA_WIDTH (32),
        .PORT_NUB   (16),
        .PRIORITY   (8),
        .LEN_W      (10),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .external_clk (clk),
        .rst          (rst),
        .cmd_vld      (cmd_vld),
        .cmd_ready    (cmd_ready),
        .cmd_dst      (cmd_dst),
        .cmd_prio     (cmd_prio),
        .cmd_len      (cmd_len),
        .cmd_seed     (cmd_seed),
        .full_in      (full_in),
        .wr_sop       (wr_sop),
        .wr_eop       (wr_eop),
        .wr_vld       (wr_vld),
        .wr_data      (wr_data),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one descriptor, waits for acceptance and records the packet.
    // full_after>0 raises full_in once that many payload words are on the bus,
    // holding it for full_len edges. stop_words>0 returns after that many words.
    task automatic run_pkt(input logic [3:0] dst, input logic [2:0] prio,
                           input logic [9:0] len, input logic [31:0] seed,
                           input int full_after, input int full_len,
                           input int stop_words);
        int  t = 0;
        int  k = 0;
        int  full_left = 0;
        bit  done = 0;
        bit  rdy;
        q_data.delete();
        n_vld = 0; n_sop = 0; n_eop = 0; n_idle = 0; n_span = 0;
        t_acc = -1; t_sop = -1;
        cmd_dst = dst; cmd_prio = prio; cmd_len = len; cmd_seed = seed;
        cmd_vld = 1'b1;
        while (t < 200 && !done) begin
            rdy = cmd_ready;
            step();
            t++;
            if (rdy && cmd_vld) begin
                cmd_vld = 1'b0;
                t_acc   = t;
            end
            if (wr_vld) begin
                if (wr_sop) begin
                    n_sop++;
                    t_sop = t;
                end else begin
                    k++;
                end
                if (wr_eop) n_eop++;
                q_data.push_back(wr_data);
                n_vld++;
            end else if (n_vld == 0) begin
                n_idle++;
            end
            if (n_vld > 0) n_span++;
            if (full_left > 0) begin
                full_left--;
                if (full_left == 0) full_in = 1'b0;
            end else if (full_after > 0 && wr_vld && !wr_sop && k == full_after) begin
                full_in   = 1'b1;
                full_left = full_len;
            end
            if (wr_vld && wr_eop) done = 1;
            if (stop_words > 0 && n_vld == stop_words) done = 1;
        end
        cmd_vld = 1'b0;
        full_in = 1'b0;
        if (!done) check_val("pkt_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_words(input string tag, input logic [31:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q_data.size())
                check_val($sformatf("%s_w%0d", tag, i), {32'd0, q_data[i]}, {32'd0, exp[i]});
            else
                check_val($sformatf("%s_w%0d_missing", tag, i), 64'd0, 64'd1);
        end
    endtask

    initial begin
        logic [31:0] exp_q[$];
        rst = 1'b1; cmd_vld = 1'b0; cmd_dst = '0; cmd_prio = '0;
        cmd_len = '0; cmd_seed = '0; full_in = 1'b0;
        repeat (3) step();

        check_val("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check_val("rst_vld_sop_eop", {61'd0, wr_vld, wr_sop, wr_eop}, 64'd0);
        check_val("rst_data", {32'd0, wr_data}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);

        rst = 1'b0;
        step();
        check_val("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        // Basic packet: header {len=4,prio=2,dst=3} = 0x223
        run_pkt(4'd3, 3'd2, 10'd4, 32'h100, 0, 0, 0);
        check_val("t1_latency", t_sop - t_acc, 64'd1);
        check_val("t1_n_vld", n_vld, 64'd5);
        check_val("t1_sop_eop", {n_sop[15:0], n_eop[15:0]}, {16'd1, 16'd1});
        exp_q = '{32'h223, 32'h100, 32'h101, 32'h102, 32'h103};
        check_words("t1", exp_q);
        check_val("t1_pkt_cnt", {48'd0, pkt_cnt}, 64'd1);
        check_val("t1_busy_gap", {63'd0, busy}, 64'd1);

        // Header-only packet: {len=0,prio=7,dst=5} = 0x75, accepted MIN_GAP+1 edges after eop
        run_pkt(4'd5, 3'd7, 10'd0, 32'hDEAD, 0, 0, 0);
        check_val("t2_accept_edge", t_acc, MIN_GAP + 1);
        check_val("t2_n_vld", n_vld, 64'd1);
        check_val("t2_sop_eop", {n_sop[15:0], n_eop[15:0]}, {16'd1, 16'd1});
        exp_q = '{32'h75};
        check_words("t2", exp_q);
        check_val("t2_pkt_cnt", {48'd0, pkt_cnt}, 64'd2);

        // Back-pressure after the skid word: {len=8,prio=0,dst=15} = 0x40F
        run_pkt(4'd15, 3'd0, 10'd8, 32'h2000, 3, 3, 0);
        check_val("t5_idle_between", n_idle, 64'd3);
        check_val("t3_n_vld", n_vld, 64'd9);
        check_val("t3_span", n_span, 64'd12);
        exp_q = '{32'h40F, 32'h2000, 32'h2001, 32'h2002, 32'h2003,
                  32'h2004, 32'h2005, 32'h2006, 32'h2007};
        check_words("t3", exp_q);
        check_val("t3_pkt_cnt", {48'd0, pkt_cnt}, 64'd3);

        // Payload wrap: {len=3,prio=1,dst=1} = 0x191
        run_pkt(4'd1, 3'd1, 10'd3, 32'hFFFF_FFFE, 0, 0, 0);
        exp_q = '{32'h191, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        check_words("t4", exp_q);
        check_val("t4_pkt_cnt", {48'd0, pkt_cnt}, 64'd4);

        // Reset mid-packet on the third payload word: {len=10,prio=3,dst=0} = 0x530
        run_pkt(4'd0, 3'd3, 10'd10, 32'h500, 0, 0, 4);
        exp_q = '{32'h530, 32'h500, 32'h501, 32'h502};
        check_words("t6", exp_q);
        rst = 1'b1;
        step();
        check_val("t6_vld_sop_eop", {61'd0, wr_vld, wr_sop, wr_eop}, 64'd0);
        check_val("t6_data", {32'd0, wr_data}, 64'd0);
        check_val("t6_busy", {63'd0, busy}, 64'd0);
        check_val("t6_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
        check_val("t6_ready_in_rst", {63'd0, cmd_ready}, 64'd0);
        rst = 1'b0;
        step();
        check_val("t6_ready_after", {63'd0, cmd_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
